// File: rtl/iddmm_pkg.sv
// rtl/iddmm_pkg.sv - shared types and constants for the IDDMM host sequencer
// Defaults for word geometry, write-enable bit positions and sequencer states.
package iddmm_pkg;

   localparam int DEF_K = 256;
   localparam int DEF_N = 16;

   localparam int WR_X = 0;
   localparam int WR_Y = 1;
   localparam int WR_M = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_REQ     = 3'd2,
      ST_COLLECT = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Plain vector encodings for the state register, kept in step with state_e.
   localparam logic [2:0] S_IDLE    = ST_IDLE;
   localparam logic [2:0] S_LOAD    = ST_LOAD;
   localparam logic [2:0] S_REQ     = ST_REQ;
   localparam logic [2:0] S_COLLECT = ST_COLLECT;
   localparam logic [2:0] S_DONE    = ST_DONE;

endpackage

// File: rtl/iddmm_host_if.sv
// rtl/iddmm_host_if.sv - operation, result and core-side signals of the IDDMM host
// IDDMM_HOST_TIMEOUT_EN adds the sticky err output.
interface iddmm_host_if
   import iddmm_pkg::*;
#(
   parameter int K = DEF_K,
   parameter int N = DEF_N
);
   localparam int ADDR_W = $clog2(N);

   logic              op_valid;
   logic              op_ready;
   logic [K*N-1:0]    op_x;
   logic [K*N-1:0]    op_y;
   logic [K*N-1:0]    op_m;
   logic [K-1:0]      op_m1;

   logic              res_valid;
   logic              res_ready;
   logic [K*N-1:0]    res_data;

   logic [2:0]        wr_ena;
   logic [ADDR_W-1:0] wr_addr;
   logic [K-1:0]      wr_x;
   logic [K-1:0]      wr_y;
   logic [K-1:0]      wr_m;
   logic [K-1:0]      wr_m1;

   logic              task_req;
   logic              task_grant;
   logic              task_end;
   logic [K-1:0]      task_res;
`ifdef IDDMM_HOST_TIMEOUT_EN
   logic              err;
`endif

   modport master (
      input  op_valid, op_x, op_y, op_m, op_m1,
      input  res_ready,
      input  task_grant, task_end, task_res,
      output op_ready, res_valid, res_data,
      output wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1,
`ifdef IDDMM_HOST_TIMEOUT_EN
      output err,
`endif
      output task_req
   );

   modport slave (
      output op_valid, op_x, op_y, op_m, op_m1,
      output res_ready,
      output task_grant, task_end, task_res,
      input  op_ready, res_valid, res_data,
      input  wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1,
`ifdef IDDMM_HOST_TIMEOUT_EN
      input  err,
`endif
      input  task_req
   );

endinterface

// File: rtl/iddmm_word_gather.sv
// rtl/iddmm_word_gather.sv - N x K serial-to-parallel capture register
// Each enabled cycle stores din into slot cnt (slot 0 = LSW) and advances cnt.
module iddmm_word_gather
   import iddmm_pkg::*;
#(
   parameter int K = DEF_K,
   parameter int N = DEF_N
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           en,
   input  logic [K-1:0]   din,
   output logic [K*N-1:0] data,
   output logic           last
);
   localparam int CW = $clog2(N) + 1;

   logic [CW-1:0] cnt;
   logic          take;

   assign take = en && (cnt < CW'(N));
   assign last = take && (cnt == CW'(N - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         cnt  <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (take) begin
         data[int'(cnt) * K +: K] <= din;
         cnt                      <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/iddmm_host.sv
// rtl/iddmm_host.sv - initiator-side sequencer for the word-serial IDDMM core
// Optional IDDMM_HOST_TIMEOUT_EN aborts a stalled core handshake and flags err.
module iddmm_host
   import iddmm_pkg::*;
#(
   parameter int K = DEF_K,
   parameter int N = DEF_N
`ifdef IDDMM_HOST_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 65535
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   iddmm_host_if.master  bus
);
   localparam int ADDR_W = $clog2(N);
   localparam int CW     = ADDR_W + 1;

   logic [2:0]     state;
   logic [K*N-1:0] sx;
   logic [K*N-1:0] sy;
   logic [K*N-1:0] sm;
   logic [K-1:0]   m1;
   logic [CW-1:0]  wcnt;

   logic accept;
   logic res_hs;
   logic gather_en;
   logic gather_last;
   logic expire;

   assign accept    = (state == S_IDLE) && bus.op_valid;
   assign res_hs    = (state == S_DONE) && bus.res_ready;
   assign gather_en = (state == S_COLLECT) && bus.task_end;

`ifdef IDDMM_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tcnt;
   logic          err_q;
   logic          running;
   logic          kick;

   assign running = (state == S_REQ) || (state == S_COLLECT);
   assign kick    = ((state == S_REQ) && bus.task_grant) || gather_en;
   assign expire  = running && !kick && (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         if (!running || kick || expire) tcnt <= '0;
         else                            tcnt <= tcnt + 1'b1;
         if (accept)      err_q <= 1'b0;
         else if (expire) err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   assign expire = 1'b0;
`endif

   // Operand shift registers present their low word to the core each LOAD cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         sx    <= '0;
         sy    <= '0;
         sm    <= '0;
         m1    <= '0;
         wcnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  sx    <= bus.op_x;
                  sy    <= bus.op_y;
                  sm    <= bus.op_m;
                  m1    <= bus.op_m1;
                  wcnt  <= '0;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               sx <= sx >> K;
               sy <= sy >> K;
               sm <= sm >> K;
               if (wcnt == CW'(N - 1)) begin
                  wcnt  <= '0;
                  state <= S_REQ;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            S_REQ: begin
               if (bus.task_grant) state <= S_COLLECT;
               else if (expire)    state <= S_IDLE;
            end
            S_COLLECT: begin
               if (gather_last)    state <= S_DONE;
               else if (expire)    state <= S_IDLE;
            end
            S_DONE: begin
               if (bus.res_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   iddmm_word_gather #(
      .K (K),
      .N (N)
   ) u_gather (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept || res_hs || expire),
      .en    (gather_en),
      .din   (bus.task_res),
      .data  (bus.res_data),
      .last  (gather_last)
   );

   always_comb begin
      bus.wr_ena       = '0;
      bus.wr_ena[WR_X] = (state == S_LOAD);
      bus.wr_ena[WR_Y] = (state == S_LOAD);
      bus.wr_ena[WR_M] = (state == S_LOAD);
   end

   assign bus.wr_addr   = wcnt[ADDR_W-1:0];
   assign bus.wr_x      = sx[K-1:0];
   assign bus.wr_y      = sy[K-1:0];
   assign bus.wr_m      = sm[K-1:0];
   assign bus.wr_m1     = m1;
   assign bus.task_req  = (state == S_REQ);
   assign bus.op_ready  = (state == S_IDLE);
   assign bus.res_valid = (state == S_DONE);

endmodule
